// File: rtl/logic_gate_checker.sv
// logic_gate_checker: self-test sequencer for a 2-input logic gate array.
// Drives a/b through the four input vectors, waits for the gates to settle,
// checks the 7-bit result against the truth table and reports pass/fail.
// Optional feature macro: LOGIC_GATE_CHECKER_ERR_LOG_EN adds first-error capture
// outputs (first_err_vec, first_err_mask).
module logic_gate_checker #(
    parameter int SETTLE_CYCLES = 2,
    parameter int LOOPS         = 1,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             a_out,
    output logic             b_out,
    input  logic [6:0]       y_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [1:0]       vec_idx
`ifdef LOGIC_GATE_CHECKER_ERR_LOG_EN
    ,
    output logic [1:0]       first_err_vec,
    output logic [6:0]       first_err_mask
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SETTLE,
        CHECK,
        DONE
    } state_t;

    localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE_CYCLES);
    localparam logic [7:0]       LOOP_LAST   = 8'(LOOPS - 1);
    localparam logic [ERR_W-1:0] ERR_ONE     = 1;
    localparam logic [ERR_W-1:0] ERR_MAX     = '1;

    state_t     state;
    state_t     next_state;
    logic [3:0] settle_cnt;
    logic [7:0] loop_cnt;
    logic [6:0] expected_y;
    logic       mismatch;

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Truth-table value the gate array must produce for the vector under test.
    always_comb begin
        expected_y = 7'h59;
        case (vec_idx)
            2'd0:    expected_y = 7'h59;
            2'd1:    expected_y = 7'h2D;
            2'd2:    expected_y = 7'h2C;
            2'd3:    expected_y = 7'h46;
            default: expected_y = 7'h59;
        endcase
    end

    // Case inequality so an undriven or X gate output is reported as a failure.
    assign mismatch = (y_in !== expected_y);

    // Next-state logic: drive, settle, check per vector; loop, then finish.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = DRIVE;
                end
            end
            DRIVE: begin
                next_state = SETTLE;
            end
            SETTLE: begin
                if (settle_cnt <= 4'd1) begin
                    next_state = CHECK;
                end
            end
            CHECK: begin
                if (vec_idx != 2'd3) begin
                    next_state = DRIVE;
                end else if (loop_cnt < LOOP_LAST) begin
                    next_state = DRIVE;
                end else begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath and registered outputs; done/pass land on the edge leaving DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_out      <= 1'b0;
            b_out      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            vec_idx    <= 2'd0;
            loop_cnt   <= 8'd0;
            settle_cnt <= 4'd0;
`ifdef LOGIC_GATE_CHECKER_ERR_LOG_EN
            first_err_vec  <= 2'd0;
            first_err_mask <= 7'd0;
`endif
        end else begin
            done <= 1'b0;
            busy <= (next_state != IDLE);
            case (state)
                IDLE: begin
                    if (start) begin
                        err_count <= '0;
                        vec_idx   <= 2'd0;
                        loop_cnt  <= 8'd0;
                        pass      <= 1'b0;
`ifdef LOGIC_GATE_CHECKER_ERR_LOG_EN
                        first_err_vec  <= 2'd0;
                        first_err_mask <= 7'd0;
`endif
                    end
                end
                DRIVE: begin
                    a_out      <= vec_idx[1];
                    b_out      <= vec_idx[0];
                    settle_cnt <= SETTLE_LOAD;
                end
                SETTLE: begin
                    settle_cnt <= settle_cnt - 4'd1;
                end
                CHECK: begin
                    if (mismatch) begin
                        if (err_count != ERR_MAX) begin
                            err_count <= err_count + ERR_ONE;
                        end
`ifdef LOGIC_GATE_CHECKER_ERR_LOG_EN
                        if (err_count == '0) begin
                            first_err_vec  <= vec_idx;
                            first_err_mask <= y_in ^ expected_y;
                        end
`else
                        // First-error capture is not built in this configuration.
`endif
                    end
                    if (vec_idx != 2'd3) begin
                        vec_idx <= vec_idx + 2'd1;
                    end else if (loop_cnt < LOOP_LAST) begin
                        loop_cnt <= loop_cnt + 8'd1;
                        vec_idx  <= 2'd0;
                    end
                end
                DONE: begin
                    done <= 1'b1;
                    pass <= (err_count == '0);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_logic_gate_checker.sv
// tb_logic_gate_checker: directed and randomized checks of logic_gate_checker
// against a behavioural gate-array model with injectable stuck-at faults.
module tb_logic_gate_checker;

    localparam int S   = 2;
    localparam int L   = 1;
    localparam int SS  = 1;
    localparam int SL  = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic start_sat;
    logic a_out, b_out, busy, done, pass;
    logic [7:0] err_count;
    logic [1:0] vec_idx;
    logic sa, sb, sbusy, sdone, spass;
    logic [1:0] serr;
    logic [1:0] svec;
    logic [6:0] fault_and;
    logic [6:0] fault_or;
    logic force_x;
    logic sat_zero;
    logic [6:0] y_main;
    logic [6:0] y_sat;
`ifdef LOGIC_GATE_CHECKER_ERR_LOG_EN
    logic [1:0] first_err_vec;
    logic [6:0] first_err_mask;
    logic [1:0] s_first_vec;
    logic [6:0] s_first_mask;
`endif

    int checks = 0;
    int errors = 0;

    // Free-running clock.
    always #5 clk = ~clk;

    // Ideal gate array: {xnor, xor, nor, nand, or, and, not_a}.
    function automatic logic [6:0] gate(input logic a, input logic b);
        return {~(a ^ b), a ^ b, ~(a | b), ~(a & b), a | b, a & b, ~a};
    endfunction

    // Gate array seen by the main checker, with stuck-at and X injection.
    always_comb y_main = force_x ? 7'bxxxxxxx : ((gate(a_out, b_out) & fault_and) | fault_or);

    // Gate array seen by the saturation checker, optionally tied to zero.
    always_comb y_sat = sat_zero ? 7'h00 : gate(sa, sb);

    logic_gate_checker #(.SETTLE_CYCLES(S), .LOOPS(L), .ERR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a_out(a_out), .b_out(b_out), .y_in(y_main),
        .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .vec_idx(vec_idx)
`ifdef LOGIC_GATE_CHECKER_ERR_LOG_EN
        , .first_err_vec(first_err_vec), .first_err_mask(first_err_mask)
`endif
    );

    logic_gate_checker #(.SETTLE_CYCLES(SS), .LOOPS(SL), .ERR_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start_sat),
        .a_out(sa), .b_out(sb), .y_in(y_sat),
        .busy(sbusy), .done(sdone), .pass(spass),
        .err_count(serr), .vec_idx(svec)
`ifdef LOGIC_GATE_CHECKER_ERR_LOG_EN
        , .first_err_vec(s_first_vec), .first_err_mask(s_first_mask)
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full run of the main checker with a given fault; optional mid-run
    // start poke and optional start hold for back-to-back runs.
    task automatic applyStimulus(input logic [6:0] am, input logic [6:0] om, input logic fx,
                                 input logic poke, input logic hold, input string tag);
        int exp_err;
        int first_v;
        logic [6:0] first_m;
        logic [6:0] good;
        logic [6:0] bad;
        logic [1:0] v;
        int done_at;
        int per;
        per = S + 2;
        fault_and = am;
        fault_or = om;
        force_x = fx;
        exp_err = 0;
        first_v = -1;
        first_m = 7'd0;
        for (int k = 0; k < 4 * L; k++) begin
            v = 2'(k % 4);
            good = gate(v[1], v[0]);
            bad = (good & am) | om;
            if (fx || (bad != good)) begin
                exp_err++;
                if (first_v < 0) begin
                    first_v = k % 4;
                    first_m = fx ? 7'bxxxxxxx : (bad ^ good);
                end
            end
        end
        start = 1'b1;
        tick();
        start = hold;
        checkOutput({tag, ":busy_at_accept"}, 32'(busy), 1);
        checkOutput({tag, ":err_cleared"}, 32'(err_count), 0);
        checkOutput({tag, ":pass_cleared"}, 32'(pass), 0);
        done_at = -1;
        for (int c = 1; c <= 60 && done_at < 0; c++) begin
            tick();
            if (poke && !hold) start = (c == 5);
            if (((c - 1) % per == 1) && (c <= 4 * L * per))
                checkOutput({tag, ":ab_seq"}, 32'({a_out, b_out}), ((c - 1) / per) % 4);
            if (done === 1'b1) done_at = c;
        end
        checkOutput({tag, ":done_cycle"}, done_at, 4 * L * (S + 2) + 1);
        checkOutput({tag, ":busy_at_done"}, 32'(busy), 0);
        checkOutput({tag, ":err_count"}, 32'(err_count), (exp_err > 255) ? 255 : exp_err);
        checkOutput({tag, ":pass"}, 32'(pass), (exp_err == 0) ? 1 : 0);
        checkOutput({tag, ":vec_idx_end"}, 32'(vec_idx), 3);
        checkOutput({tag, ":ab_hold"}, 32'({a_out, b_out}), 3);
`ifdef LOGIC_GATE_CHECKER_ERR_LOG_EN
        checkOutput({tag, ":first_vec"}, 32'(first_err_vec), (first_v < 0) ? 0 : first_v);
        checkOutput({tag, ":first_mask"}, 32'(first_err_mask), 32'(first_m));
`endif
        if (!hold) begin
            tick();
            checkOutput({tag, ":done_one_cycle"}, 32'(done), 0);
        end
    endtask

    initial begin
        int done_at;
        int exp_sat;
        int pulses;
        logic [6:0] am;
        logic [6:0] om;
        int bitpos;
        int mode;
        rst_n = 1'b0;
        start = 1'b0;
        start_sat = 1'b0;
        fault_and = 7'h7F;
        fault_or = 7'h00;
        force_x = 1'b0;
        sat_zero = 1'b0;
        tick();
        tick();
        checkOutput("reset:ab", 32'({a_out, b_out}), 0);
        checkOutput("reset:flags", 32'({busy, done, pass}), 0);
        checkOutput("reset:err", 32'(err_count), 0);
        checkOutput("reset:vec", 32'(vec_idx), 0);
`ifdef LOGIC_GATE_CHECKER_ERR_LOG_EN
        checkOutput("reset:first", 32'({first_err_vec, first_err_mask}), 0);
`endif
        rst_n = 1'b1;
        tick();
        checkOutput("idle:busy", 32'(busy), 0);

        applyStimulus(7'h7F, 7'h00, 1'b0, 1'b0, 1'b0, "T1_good");
        applyStimulus(~7'h20, 7'h00, 1'b0, 1'b0, 1'b0, "T2_stuck5");
        applyStimulus(7'h7F, 7'h00, 1'b0, 1'b1, 1'b0, "T5_poke");
        applyStimulus(7'h7F, 7'h00, 1'b1, 1'b0, 1'b0, "Tx_xin");

        applyStimulus(~7'h01, 7'h00, 1'b0, 1'b0, 1'b1, "T6_run1");
        applyStimulus(7'h7F, 7'h00, 1'b0, 1'b0, 1'b1, "T6_run2");
        applyStimulus(7'h7F, 7'h40, 1'b0, 1'b0, 1'b0, "T6_run3");

        for (int r = 0; r < 8; r++) begin
            mode = $urandom_range(0, 3);
            bitpos = $urandom_range(0, 6);
            am = 7'h7F;
            om = 7'h00;
            if (mode == 1) am[bitpos] = 1'b0;
            if (mode == 2) om[bitpos] = 1'b1;
            if (mode == 3) begin
                am = 7'($urandom) | 7'($urandom);
                om = 7'($urandom) & 7'($urandom);
            end
            applyStimulus(am, om, 1'b0, 1'b0, 1'b0, "Trand");
        end

        fault_and = ~7'h01;
        fault_or = 7'h00;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 9; c++) tick();
        checkOutput("T4:err_before_reset", 32'(err_count), 2);
        rst_n = 1'b0;
        tick();
        checkOutput("T4:ab", 32'({a_out, b_out}), 0);
        checkOutput("T4:flags", 32'({busy, done, pass}), 0);
        checkOutput("T4:err", 32'(err_count), 0);
        checkOutput("T4:vec", 32'(vec_idx), 0);
        rst_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0) pulses++;
        end
        checkOutput("T4:no_done_after_reset", pulses, 0);

        exp_sat = 0;
        for (int k = 0; k < 4 * SL; k++)
            if (gate(1'((k % 4) / 2), 1'(k % 2)) != 7'h00) exp_sat++;
        sat_zero = 1'b1;
        start_sat = 1'b1;
        tick();
        start_sat = 1'b0;
        done_at = -1;
        for (int c = 1; c <= 80 && done_at < 0; c++) begin
            tick();
            if (sdone === 1'b1) done_at = c;
        end
        checkOutput("T3:done_cycle", done_at, 4 * SL * (SS + 2) + 1);
        checkOutput("T3:err_sat", 32'(serr), (exp_sat > 3) ? 3 : exp_sat);
        checkOutput("T3:pass", 32'(spass), 0);
        tick();

        sat_zero = 1'b0;
        start_sat = 1'b1;
        tick();
        start_sat = 1'b0;
        checkOutput("T3b:err_cleared", 32'(serr), 0);
        done_at = -1;
        for (int c = 1; c <= 80 && done_at < 0; c++) begin
            tick();
            if (sdone === 1'b1) done_at = c;
        end
        checkOutput("T3b:done_cycle", done_at, 4 * SL * (SS + 2) + 1);
        checkOutput("T3b:err", 32'(serr), 0);
        checkOutput("T3b:pass", 32'(spass), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
